// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the datapath bus source selector.
//   - SRC_*_OFS : offsets added to N_REGS to form the source index of the
//                 non-register sources (register Rk has source index k).
//   - src_w()   : width of an encoded source index for a given N_REGS.
package bus_pkg;

    localparam int SRC_DIN_OFS  = 0;
    localparam int SRC_G_OFS    = 1;
    localparam int SRC_ZERO_OFS = 2;
    localparam int SRC_ONE_OFS  = 3;

    // N_REGS registers plus DIN, G, ZERO and ONE.
    function automatic int src_w(input int n_regs);
        return $clog2(n_regs + 4);
    endfunction

endpackage

// File: rtl/onehot_encode.sv
// onehot_encode
// Purely combinational one-hot encoder, reusable wherever a vector of
// enables must be turned into an index plus sanity flags.
// Ports:
//   e     in  W   enable vector
//   index out IW  position of the set bit (meaningful only when exactly one
//                 bit is set)
//   zero  out 1   no bit set
//   multi out 1   two or more bits set
module onehot_encode #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  e,
    output logic [IW-1:0] index,
    output logic          zero,
    output logic          multi
);

    // OR-ing the positions of all set bits gives the exact position when the
    // vector is one-hot; other cases are flagged by zero/multi.
    always_comb begin
        index = '0;
        for (int i = 0; i < W; i++) begin
            if (e[i]) begin
                index = index | IW'(i);
            end
        end
    end

    assign zero  = ~|e;
    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign multi = |(e & (e - W'(1)));

endmodule

// File: rtl/bus_source_reg.sv
// bus_source_reg
// Registered bus source selector for the simple processor datapath. Each
// cycle it selects one of the N_REGS register outputs, DIN, G, constant 0 or
// constant 1, and loads it into BusWires. With no enable it holds the last
// value; with several enables it holds, flags a conflict and counts it.
// Ports:
//   Clock, Resetn          clock, synchronous active-low reset
//   Rout                   register enables, MSB = R0, LSB = R(N_REGS-1)
//   r_data                 flattened register outputs, Rk at [k*DATA_W +: DATA_W]
//   DINout/din_data        DIN enable and value
//   Gout/g_data            G enable and value
//   Zout, Oneout           constant 0 / constant 1 enables
//   clr_err                clears conflict_sticky and conflict_count
//   BusWires               registered bus value
//   bus_valid              BusWires loaded from exactly one source last cycle
//   bus_src                source index of the value held in BusWires
//   conflict               one-cycle pulse per conflicting input cycle
//   conflict_sticky        set by any conflict until cleared
//   conflict_count         saturating count of conflict cycles
module bus_source_reg
    import bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_REGS = 8,
    parameter int CNT_W  = 8
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [N_REGS-1:0]          Rout,
    input  logic [N_REGS*DATA_W-1:0]   r_data,
    input  logic                       DINout,
    input  logic [DATA_W-1:0]          din_data,
    input  logic                       Gout,
    input  logic [DATA_W-1:0]          g_data,
    input  logic                       Zout,
    input  logic                       Oneout,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          BusWires,
    output logic                       bus_valid,
    output logic [src_w(N_REGS)-1:0]   bus_src,
    output logic                       conflict,
    output logic                       conflict_sticky,
    output logic [CNT_W-1:0]           conflict_count
);

    localparam int N_SRC = N_REGS + 4;
    localparam int SRC_W = src_w(N_REGS);

    logic [N_SRC-1:0]  src_en;     // bit i = enable of source index i
    logic [SRC_W-1:0]  sel_idx;
    logic              sel_none;
    logic              sel_multi;
    logic [DATA_W-1:0] sel_data;

    // Reorder the enables so that bit position equals source index; Rout is
    // MSB-first, so R0 comes from its top bit.
    always_comb begin
        src_en = '0;
        for (int k = 0; k < N_REGS; k++) begin
            src_en[k] = Rout[N_REGS-1-k];
        end
        src_en[N_REGS+SRC_DIN_OFS]  = DINout;
        src_en[N_REGS+SRC_G_OFS]    = Gout;
        src_en[N_REGS+SRC_ZERO_OFS] = Zout;
        src_en[N_REGS+SRC_ONE_OFS]  = Oneout;
    end

    onehot_encode #(
        .W  (N_SRC),
        .IW (SRC_W)
    ) u_onehot_encode (
        .e     (src_en),
        .index (sel_idx),
        .zero  (sel_none),
        .multi (sel_multi)
    );

    // AND-OR data mux; only loaded into BusWires when exactly one enable is
    // set, so the merged value in a conflict cycle never reaches the bus.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (src_en[k]) begin
                sel_data = sel_data | r_data[k*DATA_W +: DATA_W];
            end
        end
        if (DINout) sel_data = sel_data | din_data;
        if (Gout)   sel_data = sel_data | g_data;
        if (Oneout) sel_data = sel_data | DATA_W'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            BusWires        <= '0;
            bus_valid       <= 1'b0;
            bus_src         <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_count  <= '0;
        end else begin
            bus_valid <= 1'b0;
            conflict  <= sel_multi;
            if (!sel_none && !sel_multi) begin
                BusWires  <= sel_data;
                bus_src   <= sel_idx;
                bus_valid <= 1'b1;
            end
            // Clearing takes priority over a simultaneous conflict; the
            // conflict pulse above is unaffected.
            if (clr_err) begin
                conflict_sticky <= 1'b0;
                conflict_count  <= '0;
            end else if (sel_multi) begin
                conflict_sticky <= 1'b1;
                if (conflict_count != '1) begin
                    conflict_count <= conflict_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_source_reg.sv
module tb_bus_source_reg;

    typedef struct {
        logic             resetn;
        logic [7:0]       rout;
        logic [7:0][15:0] rd;
        logic             din_en;
        logic [15:0]      din;
        logic             g_en;
        logic [15:0]      g;
        logic             z_en;
        logic             one_en;
        logic             clr;
    } stim_t;

    typedef struct {
        logic [15:0] bus;
        int          src;
        logic        valid;
        logic        conf;
        logic        sticky;
        int          cnt;
    } model_t;

    logic clk;
    int   n_cmp;
    int   n_err;

    // Default instance: DATA_W=16, N_REGS=8, CNT_W=8
    logic         b_resetn, b_din_en, b_g_en, b_z_en, b_one_en, b_clr;
    logic [7:0]   b_rout;
    logic [127:0] b_rdata;
    logic [15:0]  b_din, b_g, b_bus;
    logic         b_valid, b_conf, b_sticky;
    logic [3:0]   b_src;
    logic [7:0]   b_cnt;

    // Small instance: N_REGS=4, CNT_W=2
    logic         s_resetn, s_din_en, s_g_en, s_z_en, s_one_en, s_clr;
    logic [3:0]   s_rout;
    logic [63:0]  s_rdata;
    logic [15:0]  s_din, s_g, s_bus;
    logic         s_valid, s_conf, s_sticky;
    logic [2:0]   s_src;
    logic [1:0]   s_cnt;

    model_t mb, ms;

    bus_source_reg #(.DATA_W(16), .N_REGS(8), .CNT_W(8)) dut (
        .Clock(clk), .Resetn(b_resetn), .Rout(b_rout), .r_data(b_rdata),
        .DINout(b_din_en), .din_data(b_din), .Gout(b_g_en), .g_data(b_g),
        .Zout(b_z_en), .Oneout(b_one_en), .clr_err(b_clr),
        .BusWires(b_bus), .bus_valid(b_valid), .bus_src(b_src),
        .conflict(b_conf), .conflict_sticky(b_sticky), .conflict_count(b_cnt)
    );

    bus_source_reg #(.DATA_W(16), .N_REGS(4), .CNT_W(2)) dut_small (
        .Clock(clk), .Resetn(s_resetn), .Rout(s_rout), .r_data(s_rdata),
        .DINout(s_din_en), .din_data(s_din), .Gout(s_g_en), .g_data(s_g),
        .Zout(s_z_en), .Oneout(s_one_en), .clr_err(s_clr),
        .BusWires(s_bus), .bus_valid(s_valid), .bus_src(s_src),
        .conflict(s_conf), .conflict_sticky(s_sticky), .conflict_count(s_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Collects the list of enabled sources (by source index) and applies the
    // selection rules directly on that list.
    function automatic model_t model_next(model_t m, stim_t s, int n, int cnt_max);
        model_t r;
        int     srcs[$];
        r = m;
        if (!s.resetn) begin
            r.bus = '0; r.src = 0; r.valid = 0; r.conf = 0; r.sticky = 0; r.cnt = 0;
            return r;
        end
        for (int k = 0; k < n; k++) if (s.rout[n-1-k]) srcs.push_back(k);
        if (s.din_en) srcs.push_back(n);
        if (s.g_en)   srcs.push_back(n + 1);
        if (s.z_en)   srcs.push_back(n + 2);
        if (s.one_en) srcs.push_back(n + 3);
        r.valid = 0;
        r.conf  = 0;
        if (srcs.size() == 1) begin
            r.src   = srcs[0];
            r.valid = 1;
            if (r.src < n)           r.bus = s.rd[r.src];
            else if (r.src == n)     r.bus = s.din;
            else if (r.src == n + 1) r.bus = s.g;
            else if (r.src == n + 2) r.bus = 16'h0000;
            else                     r.bus = 16'h0001;
        end else if (srcs.size() > 1) begin
            r.conf   = 1;
            r.sticky = 1;
            r.cnt    = (m.cnt < cnt_max) ? m.cnt + 1 : cnt_max;
        end
        if (s.clr) begin
            r.sticky = 0;
            r.cnt    = 0;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    function automatic stim_t idle_stim();
        stim_t s;
        s.resetn = 1'b1; s.rout = '0; s.rd = '0; s.din_en = 0; s.din = '0;
        s.g_en = 0; s.g = '0; s.z_en = 0; s.one_en = 0; s.clr = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim(int n);
        stim_t s;
        int    mode, src;
        s = idle_stim();
        for (int k = 0; k < 8; k++) s.rd[k] = 16'($urandom);
        s.din = 16'($urandom);
        s.g   = 16'($urandom);
        mode  = $urandom_range(0, 9);
        if (mode <= 5) begin
            src = $urandom_range(0, n + 3);
            if (src < n)           s.rout[n-1-src] = 1'b1;
            else if (src == n)     s.din_en = 1'b1;
            else if (src == n + 1) s.g_en = 1'b1;
            else if (src == n + 2) s.z_en = 1'b1;
            else                   s.one_en = 1'b1;
        end else if (mode >= 8) begin
            s.rout   = 8'($urandom) & 8'((1 << n) - 1);
            s.din_en = 1'($urandom_range(0, 1));
            s.g_en   = 1'($urandom_range(0, 1));
            s.z_en   = 1'($urandom_range(0, 1));
            s.one_en = 1'($urandom_range(0, 1));
        end
        s.clr    = ($urandom_range(0, 15) == 0);
        s.resetn = ($urandom_range(0, 49) != 0);
        return s;
    endfunction

    // Drives both instances for one cycle, advances the models, and returns
    // 1 time unit after the sampling edge.
    task automatic step(input stim_t sb, input stim_t ss);
        @(negedge clk);
        b_resetn = sb.resetn; b_rout = sb.rout; b_rdata = sb.rd;
        b_din_en = sb.din_en; b_din = sb.din; b_g_en = sb.g_en; b_g = sb.g;
        b_z_en = sb.z_en; b_one_en = sb.one_en; b_clr = sb.clr;
        s_resetn = ss.resetn; s_rout = ss.rout[3:0]; s_rdata = ss.rd[3:0];
        s_din_en = ss.din_en; s_din = ss.din; s_g_en = ss.g_en; s_g = ss.g;
        s_z_en = ss.z_en; s_one_en = ss.one_en; s_clr = ss.clr;
        mb = model_next(mb, sb, 8, 255);
        ms = model_next(ms, ss, 4, 3);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t sb, ss;
        for (int c = 0; c < 2; c++) begin
            sb = rand_stim(8); sb.resetn = 1'b0;
            ss = rand_stim(4); ss.resetn = 1'b0;
            step(sb, ss);
            n_cmp++; if (b_bus !== 16'h0)  begin n_err++; $display("FAIL reset_bus got %h want 0000", b_bus); end
            n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", b_valid); end
            n_cmp++; if (b_src !== 4'd0)   begin n_err++; $display("FAIL reset_src got %0d want 0", b_src); end
            n_cmp++; if (b_conf !== 1'b0)  begin n_err++; $display("FAIL reset_conflict got %b want 0", b_conf); end
            n_cmp++; if (b_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got %b want 0", b_sticky); end
            n_cmp++; if (b_cnt !== 8'd0)   begin n_err++; $display("FAIL reset_count got %0d want 0", b_cnt); end
            n_cmp++; if ({s_bus, s_valid, s_src, s_conf, s_sticky, s_cnt} !== 24'h0)
                begin n_err++; $display("FAIL reset_small got bus=%h v=%b src=%0d c=%b s=%b n=%0d want all 0",
                                        s_bus, s_valid, s_src, s_conf, s_sticky, s_cnt); end
        end
    endtask

    task automatic test_reg_select();
        stim_t sb;
        sb = idle_stim();
        sb.rout  = 8'b0010_0000;
        sb.rd[2] = 16'hA5A5;
        sb.rd[5] = 16'h5A5A;
        step(sb, idle_stim());
        n_cmp++; if (b_bus !== 16'hA5A5) begin n_err++; $display("FAIL regsel_bus got %h want a5a5", b_bus); end
        n_cmp++; if (b_src !== 4'd2)     begin n_err++; $display("FAIL regsel_src got %0d want 2", b_src); end
        n_cmp++; if (b_valid !== 1'b1)   begin n_err++; $display("FAIL regsel_valid got %b want 1", b_valid); end
    endtask

    task automatic test_idle_hold();
        stim_t sb;
        sb = idle_stim();
        sb.din_en = 1'b1; sb.din = 16'h1234;
        step(sb, idle_stim());
        n_cmp++; if (b_bus !== 16'h1234) begin n_err++; $display("FAIL din_bus got %h want 1234", b_bus); end
        n_cmp++; if (b_src !== 4'd8)     begin n_err++; $display("FAIL din_src got %0d want 8", b_src); end
        for (int c = 0; c < 3; c++) begin
            sb = idle_stim();
            sb.din = 16'hFFFF; sb.g = 16'hFFFF;
            step(sb, idle_stim());
            n_cmp++; if (b_bus !== 16'h1234) begin n_err++; $display("FAIL idle_bus got %h want 1234", b_bus); end
            n_cmp++; if (b_valid !== 1'b0)   begin n_err++; $display("FAIL idle_valid got %b want 0", b_valid); end
            n_cmp++; if (b_src !== 4'd8)     begin n_err++; $display("FAIL idle_src got %0d want 8", b_src); end
        end
        sb = idle_stim();
        sb.g_en = 1'b1; sb.g = 16'hBEEF;
        step(sb, idle_stim());
        n_cmp++; if (b_bus !== 16'hBEEF) begin n_err++; $display("FAIL g_bus got %h want beef", b_bus); end
        n_cmp++; if (b_src !== 4'd9)     begin n_err++; $display("FAIL g_src got %0d want 9", b_src); end
        n_cmp++; if (b_valid !== 1'b1)   begin n_err++; $display("FAIL g_valid got %b want 1", b_valid); end
        sb = idle_stim();
        sb.one_en = 1'b1;
        step(sb, idle_stim());
        n_cmp++; if (b_bus !== 16'h0001) begin n_err++; $display("FAIL one_bus got %h want 0001", b_bus); end
        n_cmp++; if (b_src !== 4'd11)    begin n_err++; $display("FAIL one_src got %0d want 11", b_src); end
    endtask

    // Follows test_idle_hold, so BusWires holds 0001 from the ONE source.
    task automatic test_conflict();
        stim_t sb;
        sb = idle_stim();
        sb.g_en = 1'b1; sb.g = 16'hDEAD;
        sb.rout = 8'b1000_0000; sb.rd[0] = 16'hCAFE;
        step(sb, idle_stim());
        n_cmp++; if (b_bus !== 16'h0001) begin n_err++; $display("FAIL conf_bus got %h want 0001", b_bus); end
        n_cmp++; if (b_src !== 4'd11)    begin n_err++; $display("FAIL conf_src got %0d want 11", b_src); end
        n_cmp++; if (b_valid !== 1'b0)   begin n_err++; $display("FAIL conf_valid got %b want 0", b_valid); end
        n_cmp++; if (b_conf !== 1'b1)    begin n_err++; $display("FAIL conf_pulse got %b want 1", b_conf); end
        n_cmp++; if (b_sticky !== 1'b1)  begin n_err++; $display("FAIL conf_sticky got %b want 1", b_sticky); end
        n_cmp++; if (b_cnt !== 8'd1)     begin n_err++; $display("FAIL conf_count got %0d want 1", b_cnt); end
        step(idle_stim(), idle_stim());
        n_cmp++; if (b_conf !== 1'b0)    begin n_err++; $display("FAIL conf_pulse_end got %b want 0", b_conf); end
        n_cmp++; if (b_sticky !== 1'b1)  begin n_err++; $display("FAIL conf_sticky_hold got %b want 1", b_sticky); end
        n_cmp++; if (b_cnt !== 8'd1)     begin n_err++; $display("FAIL conf_count_hold got %0d want 1", b_cnt); end
    endtask

    task automatic test_saturation();
        stim_t ss;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        ss = idle_stim();
        ss.clr = 1'b1;
        step(idle_stim(), ss);
        n_cmp++; if (s_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clear got %0d want 0", s_cnt); end
        for (int c = 0; c < 5; c++) begin
            ss = idle_stim();
            ss.z_en = 1'b1; ss.one_en = 1'b1;
            step(idle_stim(), ss);
            n_cmp++; if (s_cnt !== exp_cnt[c]) begin n_err++; $display("FAIL sat_count[%0d] got %0d want %0d", c, s_cnt, exp_cnt[c]); end
            n_cmp++; if (s_conf !== 1'b1)      begin n_err++; $display("FAIL sat_pulse[%0d] got %b want 1", c, s_conf); end
            n_cmp++; if (s_sticky !== 1'b1)    begin n_err++; $display("FAIL sat_sticky[%0d] got %b want 1", c, s_sticky); end
        end
    endtask

    task automatic test_clear_precedence();
        stim_t ss;
        ss = idle_stim();
        ss.rout = 4'b0001; ss.rd[3] = 16'h3C3C; ss.rd[0] = 16'h1111;
        step(idle_stim(), ss);
        n_cmp++; if (s_bus !== 16'h3C3C) begin n_err++; $display("FAIL r3_bus got %h want 3c3c", s_bus); end
        n_cmp++; if (s_src !== 3'd3)     begin n_err++; $display("FAIL r3_src got %0d want 3", s_src); end
        n_cmp++; if (s_valid !== 1'b1)   begin n_err++; $display("FAIL r3_valid got %b want 1", s_valid); end
        ss = idle_stim();
        ss.rout = 4'b0011; ss.clr = 1'b1;
        step(idle_stim(), ss);
        n_cmp++; if (s_conf !== 1'b1)    begin n_err++; $display("FAIL clrprec_pulse got %b want 1", s_conf); end
        n_cmp++; if (s_sticky !== 1'b0)  begin n_err++; $display("FAIL clrprec_sticky got %b want 0", s_sticky); end
        n_cmp++; if (s_cnt !== 2'd0)     begin n_err++; $display("FAIL clrprec_count got %0d want 0", s_cnt); end
        n_cmp++; if (s_bus !== 16'h3C3C) begin n_err++; $display("FAIL clrprec_bus got %h want 3c3c", s_bus); end
    endtask

    task automatic test_random();
        stim_t sb, ss;
        for (int c = 0; c < 400; c++) begin
            sb = rand_stim(8);
            ss = rand_stim(4);
            step(sb, ss);
            n_cmp++; if (b_bus !== mb.bus)         begin n_err++; $display("FAIL rnd_bus c=%0d got %h want %h", c, b_bus, mb.bus); end
            n_cmp++; if (b_src !== 4'(mb.src))     begin n_err++; $display("FAIL rnd_src c=%0d got %0d want %0d", c, b_src, mb.src); end
            n_cmp++; if (b_valid !== mb.valid)     begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, b_valid, mb.valid); end
            n_cmp++; if (b_conf !== mb.conf)       begin n_err++; $display("FAIL rnd_conflict c=%0d got %b want %b", c, b_conf, mb.conf); end
            n_cmp++; if (b_sticky !== mb.sticky)   begin n_err++; $display("FAIL rnd_sticky c=%0d got %b want %b", c, b_sticky, mb.sticky); end
            n_cmp++; if (b_cnt !== 8'(mb.cnt))     begin n_err++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, b_cnt, mb.cnt); end
            n_cmp++; if (s_bus !== ms.bus)         begin n_err++; $display("FAIL rnd_s_bus c=%0d got %h want %h", c, s_bus, ms.bus); end
            n_cmp++; if (s_src !== 3'(ms.src))     begin n_err++; $display("FAIL rnd_s_src c=%0d got %0d want %0d", c, s_src, ms.src); end
            n_cmp++; if (s_valid !== ms.valid)     begin n_err++; $display("FAIL rnd_s_valid c=%0d got %b want %b", c, s_valid, ms.valid); end
            n_cmp++; if (s_conf !== ms.conf)       begin n_err++; $display("FAIL rnd_s_conflict c=%0d got %b want %b", c, s_conf, ms.conf); end
            n_cmp++; if (s_sticky !== ms.sticky)   begin n_err++; $display("FAIL rnd_s_sticky c=%0d got %b want %b", c, s_sticky, ms.sticky); end
            n_cmp++; if (s_cnt !== 2'(ms.cnt))     begin n_err++; $display("FAIL rnd_s_count c=%0d got %0d want %0d", c, s_cnt, ms.cnt); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        mb = '{bus: '0, src: 0, valid: 0, conf: 0, sticky: 0, cnt: 0};
        ms = mb;
        test_reset();
        test_reg_select();
        test_idle_hold();
        test_conflict();
        test_saturation();
        test_clear_precedence();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_source_reg.md
# bus_source_reg

Registered, parametrised bus source selector for the simple processor datapath. Each cycle it picks one of N_REGS register outputs, DIN, G, constant 0 or constant 1 to drive BusWires. Unlike a purely combinational selector, it:
- registers the bus value;
- keeps the last good value when no source is enabled;
- detects multi-driver conflicts and counts them for debug.

It sits between the register file / ALU result register G and the shared bus feeding A, G, and the register inputs.

## Interface
Parameters:
- DATA_W, 16, bus and data width in bits
- N_REGS, 8, number of general registers (R0..R(N_REGS-1)), 2..16
- CNT_W, 8, width of the saturating conflict counter

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Resetn  in  1  reset, synchronous, active-low
- Rout  in  N_REGS  one-hot register enables; bit N_REGS-1 = R0, bit 0 = R(N_REGS-1) (MSB-first)
- r_data  in  N_REGS*DATA_W  flattened register outputs; slice [k*DATA_W +: DATA_W] = Rk
- DINout  in  1  drive DIN onto bus
- din_data  in  DATA_W  DIN value
- Gout  in  1  drive G onto bus
- g_data  in  DATA_W  G value
- Zout  in  1  drive constant 0
- Oneout  in  1  drive constant 1 (zero-extended)
- clr_err  in  1  clear conflict_sticky and conflict_count
- BusWires  out  DATA_W  registered bus value
- bus_valid  out  1  BusWires was loaded from exactly one source last cycle
- bus_src  out  $clog2(N_REGS+4)  encoded index of the source in BusWires
- conflict  out  1  one-cycle pulse: more than one enable in the previous cycle
- conflict_sticky  out  1  set by any conflict, cleared by clr_err or reset
- conflict_count  out  CNT_W  saturating count of conflict cycles

## Operation
- Enable vector E = {Rout, DINout, Gout, Zout, Oneout}; N_REGS+4 bits total.
- Source indices:
  - Rk = k
  - DIN = N_REGS
  - G = N_REGS+1
  - ZERO = N_REGS+2
  - ONE = N_REGS+3
- popcount(E) == 1:
  - BusWires <= selected data;
  - bus_src <= its index;
  - bus_valid <= 1.
- popcount(E) == 0 (idle): BusWires and bus_src hold; bus_valid <= 0. No X or Z is ever driven.
- popcount(E) >= 2 (conflict):
  - BusWires and bus_src hold;
  - bus_valid <= 0;
  - conflict <= 1;
  - conflict_sticky <= 1;
  - conflict_count increments, saturating at 2^CNT_W-1.
- clr_err alone: sticky <= 0 and count <= 0 on the same edge.
- clr_err together with a conflict: clear wins for sticky and count; the conflict pulse still asserts.
- Constant ONE = DATA_W'(1).
- The block has no FSM; state is the output registers plus the counter.

## Timing
- Latency: 1 cycle from the enables/data sampled at edge t to BusWires at t+1.
- Data inputs are sampled on the same edge as the enables. Changing data with an unchanged enable updates BusWires on the next edge.
- Reset (Resetn=0 at an edge), all outputs:
  - BusWires = 0
  - bus_valid = 0
  - bus_src = 0
  - conflict = 0
  - conflict_sticky = 0
  - conflict_count = 0
- Reset mid-operation overrides every other input on that edge.
- conflict is high for exactly one cycle per conflicting input cycle. Back-to-back conflicts keep it high continuously.
- Counter at saturation: stays at max; sticky stays 1.

## Structure
- Shared package bus_pkg holds:
  - source-index offset constants (SRC_DIN_OFS=0, SRC_G_OFS=1, SRC_ZERO_OFS=2, SRC_ONE_OFS=3, added to N_REGS);
  - the bus_src width function.
- One sub-module: onehot_encode. It is parametrised on width W; inputs E; outputs index, zero and multi flags. It is purely combinational and reusable by the control FSM.
- The top level holds the data selection, output registers and the counter.

## Test plan
Default parameters unless stated.
- Reset: Resetn=0 for 2 cycles with random inputs -> all outputs 0 at each edge.
- Register select: Rout=8'b0010_0000, R2=16'hA5A5 -> next cycle BusWires=A5A5, bus_src=2, bus_valid=1.
- Idle hold, then G and constants:
  - drive DIN=16'h1234 for one cycle -> BusWires=1234;
  - then all enables 0 for 3 cycles -> BusWires stays 1234, bus_valid=0;
  - then Gout=1 with g_data=16'hBEEF -> BEEF, bus_src=9;
  - then Oneout=1 -> 0001, bus_src=11.
- Conflict: Gout=1 and Rout=8'b1000_0000 together -> BusWires unchanged, conflict pulse for 1 cycle, sticky=1, count=1.
- Saturation: CNT_W=2, 5 consecutive conflict cycles -> count 1,2,3,3,3; conflict high for all 5.
- Clear precedence: clr_err=1 in the same cycle as a conflict -> sticky=0, count=0, conflict=1. With N_REGS=4, Rout=4'b0001 selects R3, bus_src=3.
